// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter that pulls bytes from a FIFO read port.
// A byte is requested with a one-cycle RREQ pulse (FETCH), captured from DIN
// one cycle later (LOAD), then shifted out LSB first between a start and a
// stop bit, each bit lasting CLKS_PER_BIT clock cycles.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       FE,
  output logic       RREQ,
  output logic       TX,
  output logic       BUSY
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == LastCnt);

  // Next-state, datapath and registered-TX value computation.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    case (state_q)
      StIdle: begin
        if (!FE) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        // FIFO DO has been valid since the end of FETCH.
        shift_d = DIN;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        state_d = StStart;
      end
      StStart: begin
        cnt_d = bit_end ? 16'd0 : 16'(cnt_q + 16'd1);
        if (bit_end) state_d = StData;
      end
      StData: begin
        cnt_d = bit_end ? 16'd0 : 16'(cnt_q + 16'd1);
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = 3'(idx_q + 3'd1);
          if (idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = bit_end ? 16'd0 : 16'(cnt_q + 16'd1);
        if (bit_end) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // TX is registered, so it is derived from the state being entered; this
    // makes the line fall exactly on the edge that enters START.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      shift_q <= 8'd0;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Moore decodes of the state register; both drop immediately on reset.
  assign RREQ = (state_q == StFetch);
  assign BUSY = (state_q != StIdle);
  assign TX   = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx. A queue models the
// FIFO; each frame is predicted from the byte popped on RREQ using the 8N1
// frame rule and cycle arithmetic.
module tb_uart_tx;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       fe;
  logic       rreq;
  logic       tx;
  logic       busy;

  int checks;
  int failures;
  logic [7:0] fifo_q[$];

  uart_tx #(
    .CLKS_PER_BIT(N)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .DIN (din),
    .FE  (fe),
    .RREQ(rreq),
    .TX  (tx),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Idle line: no request, TX high, not busy.
  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      din = 8'($urandom);
      check_eq({tag, "_rreq"}, 32'(rreq), 32'd0);
      check_eq({tag, "_tx"}, 32'(tx), 32'd1);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  // Count negedges until RREQ is seen (bounded) and compare to the expected latency.
  task automatic wait_rreq(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rreq && n < 60);
    check_eq(tag, 32'(n), 32'(exp_n));
  endtask

  // Called at the negedge of the FETCH cycle. Pops the FIFO model, presents the
  // byte on DIN through LOAD, then scrambles DIN and checks every cycle of the
  // frame up to abort_k (k=42 is the first IDLE cycle after the frame).
  task automatic frame_body(input string tag, input int abort_k);
    logic [7:0] b;
    logic [9:0] frame;
    logic       exp_tx;
    int         bit_no;
    b = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
    din = b;
    fe = (fifo_q.size() == 0);
    frame = {1'b1, b, 1'b0};
    check_eq({tag, "_fetch_rreq"}, 32'(rreq), 32'd1);
    check_eq({tag, "_fetch_tx"}, 32'(tx), 32'd1);
    check_eq({tag, "_fetch_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 42 && k <= abort_k; k++) begin
      @(negedge clk);
      if (k >= 2) din = 8'($urandom);
      if (k == 42) begin
        check_eq({tag, "_end_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_end_tx"}, 32'(tx), 32'd1);
        check_eq({tag, "_end_rreq"}, 32'(rreq), 32'd0);
      end else begin
        if (k == 1) begin
          exp_tx = 1'b1;
        end else begin
          bit_no = (k - 2) / N;
          exp_tx = frame[bit_no];
        end
        check_eq({tag, "_rreq"}, 32'(rreq), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_tx"}, 32'(tx), 32'(exp_tx));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    fe = 1'b0;
    din = 8'h00;
    fifo_q.push_back(8'hA5);

    // Reset held with a non-empty FIFO: nothing may be requested.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_rreq", 32'(rreq), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    wait_rreq("rst_first_rreq", 1);

    // Single byte 0xA5, then FIFO empty.
    frame_body("a5", 42);
    check_idle("a5_after", 10);

    // Back-to-back 0x00 then 0xFF: second RREQ 43 cycles after the first.
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fe = 1'b0;
    wait_rreq("b2b_first", 1);
    frame_body("b2b0", 42);
    wait_rreq("b2b_gap", 1);
    frame_body("b2b1", 42);
    check_idle("b2b_after", 3);

    // Empty FIFO for 1000 cycles.
    check_idle("empty", 1000);

    // Reset during DATA bit 3 of 0x0F; 0x3C must follow as a full frame.
    fifo_q.push_back(8'h0F);
    fifo_q.push_back(8'h3C);
    fe = 1'b0;
    wait_rreq("abort_rreq", 1);
    frame_body("abort", 19);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rreq", 32'(rreq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_hold_rreq", 32'(rreq), 32'd0);
      check_eq("abort_hold_tx", 32'(tx), 32'd1);
    end
    rst = 1'b0;
    wait_rreq("abort_restart", 1);
    frame_body("after_abort", 42);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      check_idle("rnd_gap", int'($urandom_range(0, 5)));
      fifo_q.push_back(8'($urandom));
      fe = 1'b0;
      wait_rreq("rnd_rreq", 1);
      frame_body("rnd", 42);
    end
    check_idle("final", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: CLKS_PER_BIT, default 434, CLK cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-003 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-004 Port: RST  input  1  asynchronous active-high reset.
REQ-005 Port: DIN  input  8  byte from the FIFO read port (FIFO DO).
REQ-006 Port: FE  input  1  FIFO empty flag.
REQ-007 Port: RREQ  output  1  FIFO read request; connects to the FIFO RREQ.
REQ-008 Port: TX  output  1  serial line; idle high; registered.
REQ-009 Port: BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-011 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-012 IDLE: FE sampled every cycle; FE=0 -> FETCH; FE=1 -> stay in IDLE, TX=1.
REQ-013 FETCH: lasts 1 cycle; RREQ=1 only in this state, so each RREQ pulse is exactly one cycle long; then -> LOAD.
REQ-014 LOAD: lasts 1 cycle; the byte presented on DIN (FIFO DO, updated at the end of FETCH) is captured into an 8-bit shift register; the baud counter clears; then -> START.
REQ-015 TX SHALL fall on the clock edge that enters START, 2 cycles after the RREQ rising edge.
REQ-016 The baud counter SHALL count 0..CLKS_PER_BIT-1 with a width of 16 bits; a bit period ends when the count reaches CLKS_PER_BIT-1, and the count then wraps to 0.
REQ-017 START -> DATA after one bit period.
REQ-018 DATA SHALL drive TX from shift register bit 0 and shift right once per bit period.
REQ-019 A 3-bit bit index SHALL count 0..7; DATA -> STOP after the period in which the index equals 7.
REQ-020 STOP: TX=1 for one bit period, then -> IDLE.
REQ-021 Total BUSY-high time per frame SHALL be 2 + 10*CLKS_PER_BIT cycles.
REQ-022 Back-to-back bytes: the IDLE, FETCH and LOAD states add exactly 3 extra TX-high cycles between the end of one stop bit and the next start bit.
REQ-023 FE SHALL be ignored in every state except IDLE.
REQ-024 RREQ SHALL never be asserted when FE was 1 in the preceding IDLE cycle, so stale FIFO data is never transmitted.
REQ-025 DIN changes after LOAD SHALL NOT affect the frame in progress.

Reset
REQ-026 When RST=1, the block SHALL immediately (asynchronously) set state=IDLE, TX=1, RREQ=0, BUSY=0, and clear the shift register, baud counter and bit index.
REQ-027 RST asserted mid-frame SHALL abort the frame with TX high in the same cycle; the byte already read from the FIFO is discarded and not retransmitted.
REQ-028 While RST=1, no RREQ SHALL be issued regardless of FE.
REQ-029 After RST deasserts, the first FE sample SHALL occur in IDLE on the next rising edge.

Verification (CLKS_PER_BIT=4)
REQ-030 Reset: RST=1 with FE=0 -> TX=1, RREQ=0, BUSY=0 throughout; first RREQ pulse exactly 1 cycle after RST deasserts.
REQ-031 Single byte: FIFO holds 0xA5 -> one 1-cycle RREQ pulse; TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; BUSY high for 42 cycles; FE=1 afterwards -> TX stays 1.
REQ-032 Back-to-back: FIFO holds 0x00 then 0xFF -> two RREQ pulses 43 cycles apart; the first stop bit plus gap is 7 high cycles; the second frame's data bits are all 1.
REQ-033 Empty FIFO: FE held 1 for 1000 cycles -> RREQ never asserted, TX=1, BUSY=0.
REQ-034 Mid-frame reset: RST pulsed during DATA bit 3 of 0x0F -> TX=1 and BUSY=0 in the same cycle; after release with FE=0, the next byte is sent as a complete frame starting with a full 4-cycle start bit.
REQ-035 DIN isolation: DIN toggled randomly every cycle after LOAD -> the transmitted bits equal the byte captured at LOAD.
